radar_frame_buffer: RTL and testbench

Upstream feeder for the SPI transmit stage. It captures a frame of radar sample bytes into an internal RAM and raises ram_full once the frame is complete. It then serves the bytes one at a time to the SPI stage through a request/valid read port. After the last byte is read, it drops ram_full and starts capturing the next frame.

---
 rtl/radar_pkg.sv | 14 +
 rtl/radar_frame_buffer_if.sv | 29 ++
 rtl/frame_ram.sv | 39 +++
 rtl/radar_frame_buffer.sv | 188 ++++++++++++++++++
 tb/tb_radar_frame_buffer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/radar_pkg.sv
// Shared types and default sizes for the radar frame buffer.
package radar_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2,
    DRAIN = 2'd3
  } buf_state_t;

  localparam int unsigned RADAR_BYTE_W      = 8;
  localparam int unsigned RADAR_FRAME_DEPTH = 16;

endpackage

// File: rtl/radar_frame_buffer_if.sv
// Sample-capture and byte-read port bundle between the feeder and the SPI stage.
interface radar_frame_buffer_if
  import radar_pkg::*;
#(
  parameter int unsigned DATA_W = RADAR_BYTE_W,
  parameter int unsigned CNT_W  = 16
);

  logic              radarok;
  logic [DATA_W-1:0] smp_data;
  logic              smp_valid;
  logic              rd_req;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              ram_full;
  logic [CNT_W-1:0]  frame_cnt;
  logic [CNT_W-1:0]  ovf_cnt;

  modport master (
    output radarok, smp_data, smp_valid, rd_req,
    input  rd_data, rd_valid, ram_full, frame_cnt, ovf_cnt
  );

  modport slave (
    input  radarok, smp_data, smp_valid, rd_req,
    output rd_data, rd_valid, ram_full, frame_cnt, ovf_cnt
  );

endinterface

// File: rtl/frame_ram.sv
// Single-clock simple dual-port RAM, one write port and one registered read port.
module frame_ram
  import radar_pkg::*;
#(
  parameter int unsigned DATA_W = RADAR_BYTE_W,
  parameter int unsigned DEPTH  = RADAR_FRAME_DEPTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register holds its value until the next enabled read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/radar_frame_buffer.sv
// Captures one radar frame into RAM and serves it byte-by-byte to the SPI stage.
// Define FRAME_CHECKSUM_EN to append an XOR checksum byte after each drained frame.
module radar_frame_buffer
  import radar_pkg::*;
#(
  parameter int unsigned DATA_W = RADAR_BYTE_W,
  parameter int unsigned DEPTH  = RADAR_FRAME_DEPTH,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  radar_frame_buffer_if.slave bus
);

  localparam int unsigned       ADDR_W    = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  buf_state_t        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              ram_full_q, ram_full_d;
  logic              rd_valid_q, rd_valid_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;
  logic              wr_en_c;
  logic              rd_en_c;
  logic [DATA_W-1:0] ram_rdata;

`ifdef FRAME_CHECKSUM_EN
  logic [DATA_W-1:0] csum_acc_q, csum_acc_d;
  logic [DATA_W-1:0] csum_data_q, csum_data_d;
  logic              csum_pend_q, csum_pend_d;
  logic              sel_csum_q, sel_csum_d;
`endif

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_full_d  = ram_full_q;
    rd_valid_d  = 1'b0;
    done_d      = done_q;
    frame_cnt_d = frame_cnt_q;
    ovf_cnt_d   = ovf_cnt_q;
    wr_en_c     = 1'b0;
    rd_en_c     = 1'b0;
`ifdef FRAME_CHECKSUM_EN
    csum_acc_d  = csum_acc_q;
    csum_data_d = csum_data_q;
    csum_pend_d = csum_pend_q;
    sel_csum_d  = sel_csum_q;
`endif
    // Loss of the front end discards any partial frame; counters and rd_data survive.
    if (!bus.radarok) begin
      state_d    = IDLE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      ram_full_d = 1'b0;
      done_d     = 1'b0;
`ifdef FRAME_CHECKSUM_EN
      csum_pend_d = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_d = FILL;
`ifdef FRAME_CHECKSUM_EN
          csum_acc_d = '0;
`endif
        end
        FILL: begin
          if (bus.smp_valid) begin
            wr_en_c  = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
`ifdef FRAME_CHECKSUM_EN
            csum_acc_d = csum_acc_q ^ bus.smp_data;
`endif
            if (wr_ptr_q == LAST_ADDR) begin
              state_d    = READY;
              ram_full_d = 1'b1;
            end
          end
        end
        READY, DRAIN: begin
          if (bus.smp_valid && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
          end
          // done_q marks the cycle after the final rd_valid: close out the frame.
          if (done_q) begin
            state_d     = FILL;
            ram_full_d  = 1'b0;
            rd_ptr_d    = '0;
            done_d      = 1'b0;
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
`ifdef FRAME_CHECKSUM_EN
            csum_acc_d = '0;
`endif
          end else if (bus.rd_req) begin
            state_d    = DRAIN;
            rd_valid_d = 1'b1;
`ifdef FRAME_CHECKSUM_EN
            if (csum_pend_q) begin
              csum_pend_d = 1'b0;
              done_d      = 1'b1;
              sel_csum_d  = 1'b1;
              csum_data_d = csum_acc_q;
            end else begin
              rd_en_c    = 1'b1;
              sel_csum_d = 1'b0;
              rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
              if (rd_ptr_q == LAST_ADDR) begin
                csum_pend_d = 1'b1;
              end
            end
`else
            rd_en_c  = 1'b1;
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            if (rd_ptr_q == LAST_ADDR) begin
              done_d = 1'b1;
            end
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_full_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
      ovf_cnt_q   <= '0;
`ifdef FRAME_CHECKSUM_EN
      csum_acc_q  <= '0;
      csum_data_q <= '0;
      csum_pend_q <= 1'b0;
      sel_csum_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_full_q  <= ram_full_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
      ovf_cnt_q   <= ovf_cnt_d;
`ifdef FRAME_CHECKSUM_EN
      csum_acc_q  <= csum_acc_d;
      csum_data_q <= csum_data_d;
      csum_pend_q <= csum_pend_d;
      sel_csum_q  <= sel_csum_d;
`endif
    end
  end

  frame_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_frame_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en_c),
    .waddr (wr_ptr_q),
    .wdata (bus.smp_data),
    .re    (rd_en_c),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

`ifdef FRAME_CHECKSUM_EN
  assign bus.rd_data = sel_csum_q ? csum_data_q : ram_rdata;
`else
  assign bus.rd_data = ram_rdata;
`endif
  assign bus.rd_valid  = rd_valid_q;
  assign bus.ram_full  = ram_full_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_radar_frame_buffer.sv
// Scoreboard bench for radar_frame_buffer: stimulus queues expected bytes, a monitor checks rd_valid.
module tb_radar_frame_buffer;
  import radar_pkg::*;

  localparam int unsigned DATA_W = RADAR_BYTE_W;
  localparam int unsigned DEPTH  = RADAR_FRAME_DEPTH;
  localparam int unsigned CNT_W  = 16;
`ifdef FRAME_CHECKSUM_EN
  localparam int NSERVE = DEPTH + 1;
`else
  localparam int NSERVE = DEPTH;
`endif

  typedef struct {
    logic [7:0] data;
    int         req_cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  int n_vec = 0;
  int n_err = 0;

  exp_t       q[$];
  exp_t       e;
  logic [7:0] fb [DEPTH+1];
  logic [7:0] last_byte = 8'h00;
  int         exp_frames = 0;
  int         full_rises = 0;
  int         low_run = 0;
  int         min_gap = 1000;
  logic       full_prev = 1'b0;

  radar_frame_buffer_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  radar_frame_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: pops the scoreboard on every rd_valid and tracks ram_full edges.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.ram_full && !full_prev) begin
        if (full_rises > 0 && low_run < min_gap) min_gap = low_run;
        full_rises++;
      end
      if (!bus.ram_full) low_run++;
      else low_run = 0;
      full_prev = bus.ram_full;
      if (bus.rd_valid) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_rd_valid: got rd_data 0x%0h, expected no rd_valid (cycle %0d)",
                   bus.rd_data, cyc);
        end else begin
          e = q.pop_front();
          check("rd_data", 32'(bus.rd_data), 32'(e.data));
          check("rd_latency", 32'(cyc), 32'(e.req_cyc + 1));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_frame(input logic [7:0] base, input int n, input bit chk_full);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      bus.smp_data  = base + 8'(i);
      bus.smp_valid = 1'b1;
      fb[i] = base + 8'(i);
      x = x ^ (base + 8'(i));
      if (chk_full && i == n - 1) begin
        @(negedge clk);
        check("ram_full_before_last", 32'(bus.ram_full), 32'd0);
      end
      tick();
    end
    bus.smp_valid = 1'b0;
    fb[DEPTH] = x;
    if (chk_full) begin
      @(negedge clk);
      check("ram_full_rise", 32'(bus.ram_full), 32'd1);
    end
  endtask

  // Issues NSERVE requests (gapped or back-to-back) plus one spurious trailing request.
  task automatic drain(input bit burst);
    for (int i = 0; i < NSERVE; i++) begin
      q.push_back('{data: fb[i], req_cyc: cyc});
      bus.rd_req = 1'b1;
      tick();
      if (i == NSERVE - 1) begin
        @(negedge clk);
        check("ram_full_hold_last", 32'(bus.ram_full), 32'd1);
      end
      if (!burst) begin
        bus.rd_req = (i == NSERVE - 1);
        tick();
      end
    end
    bus.rd_req = 1'b0;
    if (burst) tick();
    exp_frames++;
    last_byte = fb[NSERVE-1];
    @(negedge clk);
    check("ram_full_fall", 32'(bus.ram_full), 32'd0);
    check("frame_cnt", 32'(bus.frame_cnt), 32'(exp_frames));
    tick();
  endtask

  initial begin
    bus.radarok   = 1'b0;
    bus.smp_data  = '0;
    bus.smp_valid = 1'b0;
    bus.rd_req    = 1'b0;
    reset         = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("reset_ram_full", 32'(bus.ram_full), 32'd0);
    check("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("reset_rd_data", 32'(bus.rd_data), 32'd0);
    check("reset_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    check("reset_ovf_cnt", 32'(bus.ovf_cnt), 32'd0);

    bus.radarok = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // Spurious read while filling.
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    tick();

    // Frame 1 plus overflow strobes while READY.
    write_frame(8'h00, DEPTH, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus.smp_data  = 8'hEE;
      bus.smp_valid = 1'b1;
      tick();
    end
    bus.smp_valid = 1'b0;
    @(negedge clk);
    check("ovf_cnt_after_5", 32'(bus.ovf_cnt), 32'd5);
    check("ram_full_during_ovf", 32'(bus.ram_full), 32'd1);
    tick();
    drain(1'b0);

    // Partial frame discarded by a flush.
    write_frame(8'h50, 7, 1'b0);
    bus.radarok = 1'b0;
    tick();
    @(negedge clk);
    check("flush_ram_full", 32'(bus.ram_full), 32'd0);
    check("flush_rd_data_hold", 32'(bus.rd_data), 32'(last_byte));
    check("flush_ovf_kept", 32'(bus.ovf_cnt), 32'd5);
    check("flush_frame_kept", 32'(bus.frame_cnt), 32'd1);
    bus.radarok = 1'b1;
    tick();
    write_frame(8'hA0, DEPTH, 1'b1);
    drain(1'b0);
    check("flush_single_rise", 32'(full_rises), 32'd2);

    // Back-to-back frames with burst reads.
    write_frame(8'hC0, DEPTH, 1'b1);
    drain(1'b1);
    write_frame(8'h60, DEPTH, 1'b1);
    drain(1'b1);

    // Checksum frame: XOR of 0x01..0x10 is 0x10.
    write_frame(8'h01, DEPTH, 1'b1);
    fb[DEPTH] = 8'h10;
    drain(1'b0);

    tick();
    tick();
    check("final_frame_cnt", 32'(bus.frame_cnt), 32'd5);
    check("final_ovf_cnt", 32'(bus.ovf_cnt), 32'd5);
    check("final_full_rises", 32'(full_rises), 32'd5);
    check("min_low_gap_ok", 32'(min_gap >= 1), 32'd1);
    check("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
